// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and configuration helpers for pipelined_cla_addsub
package adder_pkg;

  localparam int GROUP_W = 4;

  function automatic int num_stages(input int width, input int seg);
    return width / seg;
  endfunction

  // Segments must be whole lookahead groups and the word must be whole segments.
  function automatic bit cfg_ok(input int width, input int seg);
    return (seg > 0) && (seg % GROUP_W == 0) && (width >= seg) && (width % seg == 0);
  endfunction

endpackage

// File: rtl/cla_segment.sv
// rtl/cla_segment.sv - combinational SEG-bit carry-lookahead adder built from 4-bit groups
module cla_segment
  import adder_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  localparam int NG = SEG / GROUP_W;
  localparam int G  = GROUP_W;

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;
  logic [NG-1:0]  gg;
  logic [NG-1:0]  gp;

  assign g = a & b;
  assign p = a ^ b;

  // Intra-group carries are flat lookahead terms; group carries chain via group G/P.
  always_comb begin
    c    = '0;
    gg   = '0;
    gp   = '0;
    c[0] = cin;
    for (int j = 0; j < NG; j++) begin
      c[j*G+1] = g[j*G] | (p[j*G] & c[j*G]);
      c[j*G+2] = g[j*G+1] | (p[j*G+1] & g[j*G]) | (p[j*G+1] & p[j*G] & c[j*G]);
      c[j*G+3] = g[j*G+2] | (p[j*G+2] & g[j*G+1]) | (p[j*G+2] & p[j*G+1] & g[j*G])
               | (p[j*G+2] & p[j*G+1] & p[j*G] & c[j*G]);
      gg[j]    = g[j*G+3] | (p[j*G+3] & g[j*G+2]) | (p[j*G+3] & p[j*G+2] & g[j*G+1])
               | (p[j*G+3] & p[j*G+2] & p[j*G+1] & g[j*G]);
      gp[j]    = &p[j*G +: G];
      c[j*G+4] = gg[j] | (gp[j] & c[j*G]);
    end
  end

  assign sum  = p ^ c[SEG-1:0];
  assign cout = c[SEG];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - segment-per-stage pipelined CLA adder/subtractor with flags
// Optional saturation on signed overflow: define ADDER_SAT_EN.
module pipelined_cla_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  localparam int N = num_stages(WIDTH, SEG);

  if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_err
    $error("pipelined_cla_addsub: WIDTH must be a multiple of SEG and SEG a multiple of 4");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign b_eff    = sub ? ~b : b;
  assign zero     = (r == '0);
  assign neg      = r[WIDTH-1];

  for (genvar k = 0; k < N; k++) begin : stg
    localparam int LO_W = SEG * (k + 1);
    localparam int HI_W = WIDTH - LO_W;

    logic [SEG-1:0] op_a;
    logic [SEG-1:0] op_b;
    logic [SEG-1:0] sum;
    logic           cin_s;
    logic           cout_s;
    logic           cmsb_s;
    logic           vin;
`ifdef ADDER_SAT_EN
    logic           sin;
`endif

    if (k == 0) begin : g_src
      assign op_a  = a[SEG-1:0];
      assign op_b  = b_eff[SEG-1:0];
      assign cin_s = sub;
      assign vin   = in_valid;
`ifdef ADDER_SAT_EN
      assign sin   = sat;
`endif
    end else begin : g_src
      assign op_a  = stg[k-1].g_mid.a_hi_q[SEG-1:0];
      assign op_b  = stg[k-1].g_mid.b_hi_q[SEG-1:0];
      assign cin_s = stg[k-1].g_mid.cy_q;
      assign vin   = stg[k-1].g_mid.vld_q;
`ifdef ADDER_SAT_EN
      assign sin   = stg[k-1].g_mid.sat_q;
`endif
    end

    cla_segment #(.SEG(SEG)) u_seg (
      .a    (op_a),
      .b    (op_b),
      .cin  (cin_s),
      .sum  (sum),
      .cout (cout_s),
      .cmsb (cmsb_s)
    );

    if (k < N - 1) begin : g_mid
      // Lower sums accumulate in lo_q; untouched operand segments ride along in *_hi_q.
      logic            vld_q;
      logic            cy_q;
      logic [LO_W-1:0] lo_q;
      logic [LO_W-1:0] lo_n;
      logic [HI_W-1:0] a_hi_q;
      logic [HI_W-1:0] b_hi_q;
      logic [HI_W-1:0] a_hi_n;
      logic [HI_W-1:0] b_hi_n;
`ifdef ADDER_SAT_EN
      logic            sat_q;
`endif

      if (k == 0) begin : g_nxt
        assign lo_n   = sum;
        assign a_hi_n = a[WIDTH-1:SEG];
        assign b_hi_n = b_eff[WIDTH-1:SEG];
      end else begin : g_nxt
        assign lo_n   = {sum, stg[k-1].g_mid.lo_q};
        assign a_hi_n = stg[k-1].g_mid.a_hi_q[HI_W+SEG-1:SEG];
        assign b_hi_n = stg[k-1].g_mid.b_hi_q[HI_W+SEG-1:SEG];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q  <= 1'b0;
          cy_q   <= 1'b0;
          lo_q   <= '0;
          a_hi_q <= '0;
          b_hi_q <= '0;
`ifdef ADDER_SAT_EN
          sat_q  <= 1'b0;
`endif
        end else if (!stall) begin
          vld_q  <= vin;
          cy_q   <= cout_s;
          lo_q   <= lo_n;
          a_hi_q <= a_hi_n;
          b_hi_q <= b_hi_n;
`ifdef ADDER_SAT_EN
          sat_q  <= sin;
`endif
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] res_fin;
      logic             ovf;

      if (k == 0) begin : g_res
        assign res = sum;
      end else begin : g_res
        assign res = {sum, stg[k-1].g_mid.lo_q};
      end

      assign ovf = cout_s ^ cmsb_s;

`ifdef ADDER_SAT_EN
      localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
      localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
      // op_a here is A's top segment, so its MSB is the sign of A.
      assign res_fin = (sin & ovf) ? (op_a[SEG-1] ? SMIN : SMAX) : res;
`else
      assign res_fin = res;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          r         <= '0;
          carry     <= 1'b0;
          overflow  <= 1'b0;
        end else if (!stall) begin
          out_valid <= vin;
          r         <= res_fin;
          carry     <= cout_s;
          overflow  <= ovf;
        end
      end
    end
  end

endmodule
